cpu_load_store: RTL and testbench
=================================

Name: cpu_load_store

Overview:
- Memory stage directly downstream of the execute-stage ALU.
- Consumes the ALU result, using it as the effective address for loads/stores or as pass-through data for all other instructions.
- Drives a single-outstanding request/acknowledge data-memory bus, aligns and sign-extends load data, and produces the write-back bundle for the register file.
- Stalls execute while a bus transaction is in flight.

Parameters:
- TIMEOUT_CYCLES, 255: maximum REQ-state cycles without mem_ack before the access is aborted with bus_error. Legal range 2..65535.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- ex_valid  in  1  execute stage presents an instruction.
- ex_ready  out  1  stage can accept; equals (state==IDLE).
- ex_result  in  32  ALU result: effective address, or write-back data.
- ex_store_data  in  32  rs2 value for stores.
- ex_mem_read  in  1  instruction is a load.
- ex_mem_write  in  1  instruction is a store.
- ex_funct3  in  3  size/sign field.
- ex_rd  in  5  destination register.
- ex_reg_write  in  1  instruction writes rd.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word-aligned address {ex_result[31:2],2'b00}.
- mem_wdata  out  32  replicated store data.
- mem_wstrb  out  4  byte enables; 0 for loads.
- mem_ack  in  1  bus completes this cycle; mem_rdata valid.
- mem_rdata  in  32  read word.
- wb_valid  out  1  write-back bundle valid (1-cycle pulse).
- wb_rd  out  5  destination register.
- wb_reg_write  out  1  register file write enable.
- wb_data  out  32  write-back value.
- misalign  out  1  1-cycle pulse: misaligned or illegal-funct3 access.
- bus_error  out  1  1-cycle pulse: ack timeout.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, so ex_ready=1.
  - All registered outputs 0, including mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, wb_*, misalign, bus_error, and the timeout counter.
  - Reset mid-transaction drops mem_req immediately and produces no write-back.
- Accept:
  - An instruction is accepted on a clock edge where ex_valid && ex_ready.
  - When both ex_mem_read and ex_mem_write are set, the store takes priority.
- Non-memory instruction:
  - Stays in IDLE.
  - The next cycle has wb_valid=1, wb_data=ex_result, wb_rd=ex_rd, wb_reg_write=ex_reg_write.
  - Throughput is 1 per cycle.
- Legality check:
  - Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: funct3 000 SB, 001 SH, 010 SW.
  - Any other funct3 is illegal.
  - Misaligned: half-word access with addr[0]=1; word access with addr[1:0]!=0.
  - Illegal or misaligned: no bus request; next cycle misalign=1, wb_valid=1, wb_reg_write=0; stays IDLE.
- Legal memory access:
  - On accept, go to REQ. mem_req=1 from the next cycle.
  - mem_we, mem_addr, mem_wdata and mem_wstrb are registered at accept and held stable until the request ends.
  - The byte offset (addr[1:0]) and funct3 are stored internally.
- Store data and strobes:
  - Byte: wdata={4{d[7:0]}}, wstrb=4'b0001<<off.
  - Half-word: wdata={2{d[15:0]}}, wstrb=4'b0011<<off.
  - Word: wdata=d, wstrb=4'b1111.
- REQ state:
  - On mem_ack: mem_req drops on that edge and the state returns to IDLE.
  - On the next cycle wb_valid=1.
  - Load write-back: wb_data is mem_rdata>>(8*off), then sign-extended (LB/LH) or zero-extended (LBU/LHU) from bit 7 or 15; LW passes the full word. wb_reg_write=ex_reg_write as captured.
  - Store write-back: wb_reg_write=0 and wb_data=0.
- Timeout:
  - The counter clears on entry to REQ and increments each REQ cycle without ack.
  - After TIMEOUT_CYCLES REQ cycles without ack, on that edge: mem_req drops, state returns to IDLE, and the next cycle has bus_error=1, wb_valid=1, wb_reg_write=0.
  - An ack arriving on the final cycle wins over the timeout.
- mem_ack outside REQ is ignored.
- Pulse outputs (wb_valid, misalign, bus_error) are high for exactly one cycle per event.
- Load latency: accept → mem_req 1 cycle; ack → wb_valid 1 cycle.

Test Plan:
- ALU pass-through: 3 back-to-back non-memory ops (ex_result=0x11,0x22,0x33, rd=1,2,3) → wb_valid on 3 consecutive cycles with matching data; ex_ready stays 1; mem_req never asserted.
- LB sign-extension: addr=0x1003, funct3=000, ack after 2 REQ cycles with rdata=0x80FF_FF7F → mem_addr=0x1000, mem_wstrb=0, wb_data=0xFFFF_FF80; repeat with LBU → 0x0000_0080; ex_ready=0 throughout REQ.
- SH store: addr=0x2002, store_data=0xDEAD_BEEF → mem_we=1, mem_wdata=0xBEEF_BEEF, mem_wstrb=4'b1100; wb_valid with wb_reg_write=0 the cycle after ack.
- Misaligned/illegal access: LW at 0x3001, then a load with funct3=011 → no mem_req; misalign pulse and wb_valid with wb_reg_write=0 each, one cycle after accept.
- Timeout: TIMEOUT_CYCLES=4, load with no ack → mem_req high exactly 4 cycles, bus_error pulse on the next cycle, ex_ready back to 1; variant with ack on the 4th cycle → normal write-back, no bus_error.
- Reset mid-transaction: drop rst_n while in REQ → mem_req=0 immediately, no wb_valid; after release, ex_ready=1 and a new SW completes normally.

Source files
------------

// File: rtl/cpu_load_store.sv
// Memory stage: turns the ALU result into a data-bus access or passes it on,
// aligns/extends load data and emits the register write-back bundle.
module cpu_load_store #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_store_data,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic        misalign,
    output logic        bus_error
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t      r_state, w_next;
    logic        r_req, r_we;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_off;
    logic [2:0]  r_f3;
    logic [4:0]  r_rd;
    logic        r_rw;
    logic [15:0] r_cnt;
    logic        r_wb_valid, r_wb_rw, r_misalign, r_bus_error;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;

    logic        w_accept, w_store, w_load, w_mem;
    logic        w_legal, w_misal, w_bad, w_go, w_tmo;
    logic [31:0] w_wdata, w_shift, w_ldata;
    logic [3:0]  w_wstrb;

    assign ex_ready     = (r_state == IDLE);
    assign mem_req      = r_req;
    assign mem_we       = r_we;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign mem_wstrb    = r_wstrb;
    assign wb_valid     = r_wb_valid;
    assign wb_rd        = r_wb_rd;
    assign wb_reg_write = r_wb_rw;
    assign wb_data      = r_wb_data;
    assign misalign     = r_misalign;
    assign bus_error    = r_bus_error;

    // Decode the incoming instruction: legality, alignment and store lanes.
    always_comb begin
        w_accept = ex_valid && (r_state == IDLE);
        w_store  = ex_mem_write;
        w_load   = ex_mem_read && !ex_mem_write;
        w_mem    = w_store || w_load;
        if (w_store)
            w_legal = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001)
                   || (ex_funct3 == 3'b010);
        else
            w_legal = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001)
                   || (ex_funct3 == 3'b010) || (ex_funct3 == 3'b100)
                   || (ex_funct3 == 3'b101);
        w_misal = ((ex_funct3[1:0] == 2'b01) && ex_result[0])
               || ((ex_funct3[1:0] == 2'b10) && (ex_result[1:0] != 2'b00));
        w_bad   = w_mem && (!w_legal || w_misal);
        w_go    = w_accept && w_mem && !w_bad;
        w_wdata = ex_store_data;
        w_wstrb = 4'b1111;
        case (ex_funct3[1:0])
            2'b00: begin
                w_wdata = {4{ex_store_data[7:0]}};
                w_wstrb = 4'b0001 << ex_result[1:0];
            end
            2'b01: begin
                w_wdata = {2{ex_store_data[15:0]}};
                w_wstrb = 4'b0011 << ex_result[1:0];
            end
            default: ;
        endcase
    end

    // Shift the read word down to the addressed lane and extend it.
    always_comb begin
        w_shift = mem_rdata >> {r_off, 3'b000};
        case (r_f3)
            3'b000:  w_ldata = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_ldata = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_ldata = {24'd0, w_shift[7:0]};
            3'b101:  w_ldata = {16'd0, w_shift[15:0]};
            default: w_ldata = mem_rdata;
        endcase
    end

    // Next state: stay in REQ until ack or the timeout budget runs out.
    always_comb begin
        w_next = r_state;
        w_tmo  = (r_state == REQ) && !mem_ack
              && (r_cnt == 16'(TIMEOUT_CYCLES - 1));
        case (r_state)
            IDLE: if (w_go) w_next = REQ;
            REQ:  if (mem_ack || w_tmo) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Bus request registers, captured access info and write-back pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_off       <= '0;
            r_f3        <= '0;
            r_rd        <= '0;
            r_rw        <= 1'b0;
            r_cnt       <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_rw     <= 1'b0;
            r_wb_data   <= '0;
            r_misalign  <= 1'b0;
            r_bus_error <= 1'b0;
        end else begin
            r_wb_valid  <= 1'b0;
            r_misalign  <= 1'b0;
            r_bus_error <= 1'b0;
            if (w_accept) begin
                if (!w_mem) begin
                    r_wb_valid <= 1'b1;
                    r_wb_rd    <= ex_rd;
                    r_wb_rw    <= ex_reg_write;
                    r_wb_data  <= ex_result;
                end else if (w_bad) begin
                    r_wb_valid <= 1'b1;
                    r_misalign <= 1'b1;
                    r_wb_rd    <= ex_rd;
                    r_wb_rw    <= 1'b0;
                    r_wb_data  <= '0;
                end else begin
                    r_req   <= 1'b1;
                    r_we    <= w_store;
                    r_addr  <= {ex_result[31:2], 2'b00};
                    r_wdata <= w_store ? w_wdata : 32'd0;
                    r_wstrb <= w_store ? w_wstrb : 4'd0;
                    r_off   <= ex_result[1:0];
                    r_f3    <= ex_funct3;
                    r_rd    <= ex_rd;
                    r_rw    <= w_load && ex_reg_write;
                    r_cnt   <= '0;
                end
            end else if (r_state == REQ) begin
                if (mem_ack) begin
                    r_req      <= 1'b0;
                    r_wb_valid <= 1'b1;
                    r_wb_rd    <= r_rd;
                    r_wb_rw    <= r_rw;
                    r_wb_data  <= r_we ? 32'd0 : w_ldata;
                end else if (w_tmo) begin
                    r_req       <= 1'b0;
                    r_bus_error <= 1'b1;
                    r_wb_valid  <= 1'b1;
                    r_wb_rd     <= r_rd;
                    r_wb_rw     <= 1'b0;
                    r_wb_data   <= '0;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_load_store.sv
// Directed bench for cpu_load_store: expected write-back bundles are queued
// at issue time and popped by an independent monitor on wb_valid.
module tb_cpu_load_store;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_result, ex_store_data;
    logic        ex_mem_read, ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic        misalign, bus_error;

    typedef struct packed {
        logic [4:0]  rd;
        logic        rw;
        logic        chk_data;
        logic [31:0] data;
        logic        mis;
        logic        berr;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    cpu_load_store #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_result(ex_result), .ex_store_data(ex_store_data),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .wb_data(wb_data), .misalign(misalign), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every wb_valid pulse must match the oldest queued bundle.
    always @(negedge clk) begin
        if (wb_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_wb", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
                chk("misalign", 32'(misalign), 32'(e.mis));
                chk("bus_error", 32'(bus_error), 32'(e.berr));
                if (e.chk_data) chk("wb_data", wb_data, e.data);
            end
        end else begin
            chk("pulse_idle", {30'd0, misalign, bus_error}, 32'd0);
        end
    end

    task automatic push(input logic [4:0] rd, input logic rw,
                        input logic cd, input logic [31:0] d,
                        input logic mis, input logic berr);
        exp_t e;
        e.rd = rd; e.rw = rw; e.chk_data = cd; e.data = d;
        e.mis = mis; e.berr = berr;
        q.push_back(e);
    endtask

    task automatic drive(input logic [31:0] res, input logic [31:0] sd,
                         input logic mr, input logic mw,
                         input logic [2:0] f3, input logic [4:0] rd,
                         input logic rw);
        ex_valid = 1'b1; ex_result = res; ex_store_data = sd;
        ex_mem_read = mr; ex_mem_write = mw; ex_funct3 = f3;
        ex_rd = rd; ex_reg_write = rw;
    endtask

    // Legal access: ack on REQ cycle ack_at (0 = never acknowledge).
    task automatic run_mem(input logic [31:0] addr, input logic [31:0] sd,
                           input logic mr, input logic mw,
                           input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] rdata, input int ack_at,
                           input logic [31:0] e_wdata,
                           input logic [3:0] e_wstrb);
        bit done;
        @(negedge clk);
        drive(addr, sd, mr, mw, f3, rd, 1'b1);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
        chk("mem_we", 32'(mem_we), 32'(mw));
        chk("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
        if (mw) chk("mem_wdata", mem_wdata, e_wdata);
        done = 0;
        for (int c = 1; c <= TO; c++) begin
            if (!done) begin
                chk("req_high", 32'(mem_req), 32'd1);
                chk("ready_low", 32'(ex_ready), 32'd0);
                if (c == ack_at) begin
                    mem_ack = 1'b1;
                    mem_rdata = rdata;
                    done = 1;
                end
                @(negedge clk);
                mem_ack = 1'b0;
            end
        end
        chk("req_dropped", 32'(mem_req), 32'd0);
        chk("ready_back", 32'(ex_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_result = '0; ex_store_data = '0;
        ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = '0;
        ex_rd = '0; ex_reg_write = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ex_ready), 32'd1);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_wb", 32'(wb_valid), 32'd0);
        rst_n = 1'b1;

        // Three back-to-back ALU results.
        push(5'd1, 1'b1, 1'b1, 32'h11, 1'b0, 1'b0);
        push(5'd2, 1'b1, 1'b1, 32'h22, 1'b0, 1'b0);
        push(5'd3, 1'b1, 1'b1, 32'h33, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("pt_ready", 32'(ex_ready), 32'd1);
            chk("pt_noreq", 32'(mem_req), 32'd0);
            drive(32'(i * 'h11), 32'd0, 1'b0, 1'b0, 3'b000, 5'(i), 1'b1);
        end
        @(negedge clk);
        ex_valid = 1'b0;
        chk("pt_noreq", 32'(mem_req), 32'd0);
        @(negedge clk);
        chk("pt_q_empty", 32'(q.size()), 32'd0);

        // LB / LBU from byte lane 3.
        push(5'd5, 1'b1, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0);
        run_mem(32'h1003, 32'd0, 1'b1, 1'b0, 3'b000, 5'd5,
                32'h80FF_FF7F, 2, 32'd0, 4'b0000);
        push(5'd6, 1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b0);
        run_mem(32'h1003, 32'd0, 1'b1, 1'b0, 3'b100, 5'd6,
                32'h80FF_FF7F, 2, 32'd0, 4'b0000);
        // LH from upper half.
        push(5'd9, 1'b1, 1'b1, 32'hFFFF_80FF, 1'b0, 1'b0);
        run_mem(32'h1002, 32'd0, 1'b1, 1'b0, 3'b001, 5'd9,
                32'h80FF_1234, 1, 32'd0, 4'b0000);

        // SH to upper half-word.
        push(5'd4, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0);
        run_mem(32'h2002, 32'hDEAD_BEEF, 1'b0, 1'b1, 3'b001, 5'd4,
                32'd0, 1, 32'hBEEF_BEEF, 4'b1100);

        // Misaligned LW and illegal funct3.
        push(5'd8, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        drive(32'h3001, 32'd0, 1'b1, 1'b0, 3'b010, 5'd8, 1'b1);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("mis_noreq", 32'(mem_req), 32'd0);
        chk("mis_ready", 32'(ex_ready), 32'd1);
        push(5'd10, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        drive(32'h3000, 32'd0, 1'b1, 1'b0, 3'b011, 5'd10, 1'b1);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("ill_noreq", 32'(mem_req), 32'd0);
        @(negedge clk);
        chk("ill_noreq2", 32'(mem_req), 32'd0);

        // Timeout with no ack, then ack on the final REQ cycle.
        push(5'd11, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        run_mem(32'h4000, 32'd0, 1'b1, 1'b0, 3'b010, 5'd11,
                32'd0, 0, 32'd0, 4'b0000);
        push(5'd12, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
        run_mem(32'h4000, 32'd0, 1'b1, 1'b0, 3'b010, 5'd12,
                32'h1234_5678, TO, 32'd0, 4'b0000);

        // Reset while a load is outstanding.
        @(negedge clk);
        drive(32'h5000, 32'd0, 1'b1, 1'b0, 3'b010, 5'd13, 1'b1);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("rmid_req", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("rmid_drop", 32'(mem_req), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rmid_ready", 32'(ex_ready), 32'd1);
        push(5'd7, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0);
        run_mem(32'h6004, 32'hCAFE_F00D, 1'b0, 1'b1, 3'b010, 5'd7,
                32'd0, 1, 32'hCAFE_F00D, 4'b1111);

        repeat (3) @(negedge clk);
        chk("q_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
